// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared constants and helpers for the backtracking Sudoku cell.
//   ADDR_*     : register-file addresses decoded on the address port.
//   cnt_width  : width of a counter able to hold the values 0..n.
package sudoku_pkg;

    localparam logic [1:0] ADDR_VALUE = 2'd0;
    localparam logic [1:0] ADDR_ELIM  = 2'd1;
    localparam logic [1:0] ADDR_GUESS = 2'd2;
    localparam logic [1:0] ADDR_RSVD  = 2'd3;

    // Bits needed to represent any count from 0 to n inclusive.
    function automatic int cnt_width(input int n);
        if (n < 1) begin
            return 1;
        end else begin
            return $clog2(n + 1);
        end
    endfunction

endpackage

// File: rtl/sudoku_snapshot_stack.sv
// sudoku_snapshot_stack: LIFO of (value, valid) snapshots used for backtracking.
//   clk, reset : clock and synchronous active-high reset (clears the pointer only).
//   push, pop  : push is ignored when full, pop when empty; pop wins if both are set.
//   din, dout  : snapshot in / current top entry (zero when empty).
//   empty, full: pointer == 0 / pointer == DEPTH.
module sudoku_snapshot_stack #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [2**AW];
    logic [PW-1:0]    ptr_r;
    logic [AW-1:0]    wr_idx_s;
    logic [AW-1:0]    rd_idx_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (ptr_r == PW'(0));
    assign full      = (ptr_r == PW'(DEPTH));
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && !pop && !full;
    assign wr_idx_s  = AW'(ptr_r);
    assign rd_idx_s  = AW'(ptr_r - PW'(1));
    assign dout      = empty ? {WIDTH{1'b0}} : mem_r[rd_idx_s];

    // Stack pointer: pop takes priority over push.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= PW'(0);
        end else if (do_pop_s) begin
            ptr_r <= ptr_r - PW'(1);
        end else if (do_push_s) begin
            ptr_r <= ptr_r + PW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Entry storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (do_push_s && !reset) begin
            mem_r[wr_idx_s] <= din;
        end
    end

endmodule

// File: rtl/sudoku_cell_bt.sv
// sudoku_cell_bt: one Sudoku cell with candidate elimination, guessing and
// snapshot/restore for backtracking search.
//   value_io        : shared bus, driven only while oe=1.
//   address, we, oe : register access (value / eliminate / guess / reserved).
//   latch_singleton : end-of-round commit of a lone candidate.
//   push, pop       : save / restore (value, valid) on the snapshot stack.
//   is_singleton, solved, conflict, cand_count : cell status from state.
//   stack_empty, stack_full, stack_err         : stack status, err is sticky.
module sudoku_cell_bt
    import sudoku_pkg::*;
#(
    parameter int N     = 9,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    inout  wire  [N-1:0]              value_io,
    input  logic [1:0]                address,
    input  logic                      we,
    input  logic                      oe,
    input  logic                      latch_singleton,
    input  logic                      push,
    input  logic                      pop,
    output logic                      is_singleton,
    output logic                      solved,
    output logic                      conflict,
    output logic [cnt_width(N)-1:0]   cand_count,
    output logic                      stack_empty,
    output logic                      stack_full,
    output logic                      stack_err
);

    localparam int CW = cnt_width(N);

    // Number of set bits in a symbol mask.
    function automatic logic [CW-1:0] popcount(input logic [N-1:0] m);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + CW'(m[i]);
        end
        return c;
    endfunction

    logic [N-1:0]   value_r;
    logic [N-1:0]   valid_r;
    logic           err_r;
    logic [N-1:0]   value_nxt_s;
    logic [N-1:0]   valid_nxt_s;
    logic           err_nxt_s;
    logic [N-1:0]   bus_s;
    logic [2*N-1:0] snap_out_s;
    logic           wr_s;
    logic           unsolved_s;

    // A write colliding with our own bus drive would read back our data, so drop it.
    assign wr_s       = we && !oe;
    assign unsolved_s = (value_r == {N{1'b0}});

    sudoku_snapshot_stack #(
        .WIDTH (2 * N),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({value_r, valid_r}),
        .dout  (snap_out_s),
        .empty (stack_empty),
        .full  (stack_full)
    );

    // Cell state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_r <= {N{1'b0}};
            valid_r <= {N{1'b1}};
            err_r   <= 1'b0;
        end else begin
            value_r <= value_nxt_s;
            valid_r <= valid_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Next state: pop beats push/we, which beat latch_singleton.
    always_comb begin
        value_nxt_s = value_r;
        valid_nxt_s = valid_r;
        err_nxt_s   = err_r;
        if (pop) begin
            if (!stack_empty) begin
                value_nxt_s = snap_out_s[2*N-1:N];
                valid_nxt_s = snap_out_s[N-1:0];
            end else begin
                err_nxt_s = 1'b1;
            end
        end else begin
            if (push && stack_full) begin
                err_nxt_s = 1'b1;
            end else begin
                err_nxt_s = err_r;
            end
            if (wr_s) begin
                case (address)
                    ADDR_VALUE: begin
                        value_nxt_s = value_io;
                        valid_nxt_s = (value_io == {N{1'b0}}) ? {N{1'b1}} : {N{1'b0}};
                    end
                    ADDR_ELIM: begin
                        valid_nxt_s = unsolved_s ? (valid_r & value_io) : {N{1'b0}};
                    end
                    ADDR_GUESS: begin
                        // Accept only a single symbol that is still a candidate.
                        if (unsolved_s && (popcount(value_io) == CW'(1)) &&
                            ((value_io & valid_r) != {N{1'b0}})) begin
                            value_nxt_s = value_io;
                            valid_nxt_s = {N{1'b0}};
                        end else begin
                            value_nxt_s = value_r;
                        end
                    end
                    default: begin
                        value_nxt_s = value_r;
                    end
                endcase
            end else if (latch_singleton) begin
                if (is_singleton && unsolved_s) begin
                    value_nxt_s = valid_r;
                    valid_nxt_s = {N{1'b0}};
                end else begin
                    valid_nxt_s = unsolved_s ? {N{1'b1}} : {N{1'b0}};
                end
            end else begin
                value_nxt_s = value_r;
            end
        end
    end

    // Read mux for the shared bus.
    always_comb begin
        bus_s = {N{1'b0}};
        case (address)
            ADDR_VALUE: bus_s = value_r;
            ADDR_ELIM:  bus_s = valid_r;
            ADDR_GUESS: bus_s = valid_r;
            default:    bus_s = {N{1'b0}};
        endcase
    end

    assign value_io = oe ? bus_s : {N{1'bz}};

    assign cand_count   = popcount(valid_r);
    assign is_singleton = (cand_count == CW'(1));
    assign solved       = !unsolved_s;
    assign conflict     = unsolved_s && (valid_r == {N{1'b0}});
    assign stack_err    = err_r;

endmodule
